// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared constants, FSM state and request-slot types for the DDR port arbiter
//   ADDR_W : byte address width of the cache/DDR address space
//   LINE_W : cache line width in bits
//   OFFS_W : byte-offset bits inside a line (line address = addr[ADDR_W-1:OFFS_W])
package ddr_arb_pkg;

  localparam int ADDR_W = 27;
  localparam int LINE_W = 128;
  localparam int OFFS_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_RD,
    WAIT_RD,
    ISSUE_WR,
    WAIT_WR
  } state_t;

  typedef struct packed {
    logic              pend;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } req_t;

  function automatic logic same_line(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:OFFS_W] == b[ADDR_W-1:OFFS_W];
  endfunction

endpackage

// File: rtl/ddr_req_slot.sv
// rtl/ddr_req_slot.sv - single-entry request holding slot with pending flag and overflow detect
//   clk, rstn : clock, asynchronous active-low reset
//   i_en      : 1-cycle request pulse; captures i_addr/i_data when the slot is free
//   i_addr    : request address
//   i_data    : request line (stored only when HAS_DATA=1, otherwise stored as 0)
//   i_clr     : transaction for this slot completes at this edge
//   o_req     : held request {pend, addr, data}
//   o_ovf     : request arrived while the slot is still occupied (request dropped)
module ddr_req_slot
  import ddr_arb_pkg::*;
#(
  parameter bit HAS_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_data,
  input  logic              i_clr,
  output req_t              o_req,
  output logic              o_ovf
);

  req_t r_req;
  logic w_busy;

  // A slot being cleared on this edge counts as free, so a back-to-back refill is accepted.
  assign w_busy = r_req.pend && !i_clr;
  assign o_ovf  = i_en && w_busy;
  assign o_req  = r_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req <= '0;
    end else if (i_en && !w_busy) begin
      r_req.pend <= 1'b1;
      r_req.addr <= i_addr;
      r_req.data <= HAS_DATA ? i_data : '0;
    end else if (i_clr) begin
      r_req.pend <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - serialises cache fill and write-back requests onto one DDR command port
//   Build option: ARB_RR_EN - alternate read/write grants when both are pending without a line hazard;
//   without it reads have fixed priority. Same-line write-back always goes before the fill.
//   clk, rstn             : clock, asynchronous active-low reset
//   cache2DDR_rd_*        : fill request (addr, en); DDR2cache_rd_fin/rd_data return the line
//   cache2DDR_wr_*        : write-back request (addr, data, en); DDR2cache_wr_fin on commit
//   ddr_cmd_*/ddr_wr_data : single command port towards the DDR controller (valid/ready)
//   ddr_rd_valid/rd_data  : read line returned; ddr_wr_done : write committed
//   arb_err               : sticky protocol-violation flag
module ddr_port_arbiter
  import ddr_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] cache2DDR_rd_addr,
  input  logic              cache2DDR_rd_en,
  output logic              DDR2cache_rd_fin,
  output logic [LINE_W-1:0] DDR2cache_rd_data,
  input  logic [ADDR_W-1:0] cache2DDR_wr_addr,
  input  logic [LINE_W-1:0] cache2DDR_wr_data,
  input  logic              cache2DDR_wr_en,
  output logic              DDR2cache_wr_fin,
  output logic              ddr_cmd_valid,
  input  logic              ddr_cmd_ready,
  output logic              ddr_cmd_wr,
  output logic [ADDR_W-1:0] ddr_cmd_addr,
  output logic [LINE_W-1:0] ddr_wr_data,
  input  logic              ddr_rd_valid,
  input  logic [LINE_W-1:0] ddr_rd_data,
  input  logic              ddr_wr_done,
  output logic              arb_err
);

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

  state_t            r_state, w_next;
  req_t              w_rd, w_wr;
  logic              w_rd_ovf, w_wr_ovf, w_rd_clr, w_wr_clr;
  logic              w_hazard, w_contested, w_rr_wr, w_grant_wr;
  logic              w_valid, w_cmd_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              r_rd_fin, r_wr_fin, r_err;
  logic [LINE_W-1:0] r_rd_data;

  assign w_rd_clr = (r_state == WAIT_RD) && ddr_rd_valid;
  assign w_wr_clr = (r_state == WAIT_WR) && ddr_wr_done;

  ddr_req_slot #(.HAS_DATA(1'b0)) u_rd_slot (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (cache2DDR_rd_en),
    .i_addr (cache2DDR_rd_addr),
    .i_data ('0),
    .i_clr  (w_rd_clr),
    .o_req  (w_rd),
    .o_ovf  (w_rd_ovf)
  );

  ddr_req_slot #(.HAS_DATA(1'b1)) u_wr_slot (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (cache2DDR_wr_en),
    .i_addr (cache2DDR_wr_addr),
    .i_data (cache2DDR_wr_data),
    .i_clr  (w_wr_clr),
    .o_req  (w_wr),
    .o_ovf  (w_wr_ovf)
  );

  assign w_hazard    = w_rd.pend && w_wr.pend && same_line(w_rd.addr, w_wr.addr);
  assign w_contested = w_rd.pend && w_wr.pend && !w_hazard;

`ifdef ARB_RR_EN
  // Remembers the winner of the last contested grant; starts as "write" so the first one goes to the read.
  logic r_last_wr;
  assign w_rr_wr = !r_last_wr;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_wr <= 1'b1;
    end else if (r_state == IDLE && w_contested) begin
      r_last_wr <= w_grant_wr;
    end
  end
`else
  assign w_rr_wr = 1'b0;
`endif

  assign w_grant_wr = w_wr.pend && (!w_rd.pend || w_hazard || (w_contested && w_rr_wr));

  // IDLE already presents the granted command, so a request can go out the cycle after capture and an
  // immediate accept skips ISSUE_x; ISSUE_x freezes the grant while the controller holds off ready.
  always_comb begin
    w_next   = r_state;
    w_valid  = 1'b0;
    w_cmd_wr = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rd.pend || w_wr.pend) begin
          w_valid  = 1'b1;
          w_cmd_wr = w_grant_wr;
          if (ddr_cmd_ready) w_next = w_grant_wr ? WAIT_WR : WAIT_RD;
          else               w_next = w_grant_wr ? ISSUE_WR : ISSUE_RD;
        end
      end
      ISSUE_RD: begin
        w_valid = 1'b1;
        if (ddr_cmd_ready) w_next = WAIT_RD;
      end
      ISSUE_WR: begin
        w_valid  = 1'b1;
        w_cmd_wr = 1'b1;
        if (ddr_cmd_ready) w_next = WAIT_WR;
      end
      WAIT_RD: if (ddr_rd_valid) w_next = IDLE;
      WAIT_WR: if (ddr_wr_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The read slot stores zero data, so selecting it drives zero write data on read commands.
  assign w_sel_addr    = w_cmd_wr ? w_wr.addr : w_rd.addr;
  assign ddr_cmd_valid = w_valid;
  assign ddr_cmd_wr    = w_cmd_wr;
  assign ddr_cmd_addr  = w_valid ? (w_sel_addr & LINE_MASK) : '0;
  assign ddr_wr_data   = w_valid ? (w_cmd_wr ? w_wr.data : w_rd.data) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_rd_fin  <= 1'b0;
      r_wr_fin  <= 1'b0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rd_fin <= w_rd_clr;
      r_wr_fin <= w_wr_clr;
      if (w_rd_clr) r_rd_data <= ddr_rd_data;
      if (w_rd_ovf || w_wr_ovf || (ddr_rd_valid && !w_rd_clr) || (ddr_wr_done && !w_wr_clr)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign DDR2cache_rd_fin  = r_rd_fin;
  assign DDR2cache_wr_fin  = r_wr_fin;
  assign DDR2cache_rd_data = r_rd_data;
  assign arb_err           = r_err;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - self-checking bench for ddr_port_arbiter (directed cases plus random traffic)
module tb_ddr_port_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic [26:0]  cache2DDR_rd_addr;
  logic         cache2DDR_rd_en;
  logic         DDR2cache_rd_fin;
  logic [127:0] DDR2cache_rd_data;
  logic [26:0]  cache2DDR_wr_addr;
  logic [127:0] cache2DDR_wr_data;
  logic         cache2DDR_wr_en;
  logic         DDR2cache_wr_fin;
  logic         ddr_cmd_valid;
  logic         ddr_cmd_ready;
  logic         ddr_cmd_wr;
  logic [26:0]  ddr_cmd_addr;
  logic [127:0] ddr_wr_data;
  logic         ddr_rd_valid;
  logic [127:0] ddr_rd_data;
  logic         ddr_wr_done;
  logic         arb_err;

  ddr_port_arbiter dut (
    .clk               (clk),
    .rstn              (rstn),
    .cache2DDR_rd_addr (cache2DDR_rd_addr),
    .cache2DDR_rd_en   (cache2DDR_rd_en),
    .DDR2cache_rd_fin  (DDR2cache_rd_fin),
    .DDR2cache_rd_data (DDR2cache_rd_data),
    .cache2DDR_wr_addr (cache2DDR_wr_addr),
    .cache2DDR_wr_data (cache2DDR_wr_data),
    .cache2DDR_wr_en   (cache2DDR_wr_en),
    .DDR2cache_wr_fin  (DDR2cache_wr_fin),
    .ddr_cmd_valid     (ddr_cmd_valid),
    .ddr_cmd_ready     (ddr_cmd_ready),
    .ddr_cmd_wr        (ddr_cmd_wr),
    .ddr_cmd_addr      (ddr_cmd_addr),
    .ddr_wr_data       (ddr_wr_data),
    .ddr_rd_valid      (ddr_rd_valid),
    .ddr_rd_data       (ddr_rd_data),
    .ddr_wr_done       (ddr_wr_done),
    .arb_err           (arb_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_count = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: two request slots plus at most one outstanding DDR transaction.
  bit           m_rp, m_wp;
  logic [26:0]  m_ra, m_wa;
  logic [127:0] m_wd;
  bit           m_busy, m_is_wr, m_acc;
  bit           m_rd_fin, m_wr_fin, m_err;
  logic [127:0] m_rd_data;
  bit           m_last_wr;

  task automatic model_reset();
    m_rp = 0; m_wp = 0; m_ra = '0; m_wa = '0; m_wd = '0;
    m_busy = 0; m_is_wr = 0; m_acc = 0;
    m_rd_fin = 0; m_wr_fin = 0; m_err = 0; m_rd_data = '0;
    m_last_wr = 1;
  endtask

  function automatic bit m_pick_wr();
    if (m_busy) return m_is_wr;
    if (m_rp && m_wp) begin
      if (m_ra[26:4] == m_wa[26:4]) return 1'b1;
`ifdef ARB_RR_EN
      return !m_last_wr;
`else
      return 1'b0;
`endif
    end
    return m_wp;
  endfunction

  always @(negedge clk) begin
    bit pw, ev, rclr, wclr;
    logic [26:0] ea;
    if (!rstn) model_reset();
    pw = m_pick_wr();
    ev = m_busy ? !m_acc : (m_rp || m_wp);
    ea = ev ? {(pw ? m_wa[26:4] : m_ra[26:4]), 4'h0} : 27'h0;
    chk("cmd_valid", 128'(ddr_cmd_valid), 128'(ev));
    chk("cmd_wr", 128'(ddr_cmd_wr), 128'(ev && pw));
    chk("cmd_addr", 128'(ddr_cmd_addr), 128'(ea));
    chk("wr_data", ddr_wr_data, (ev && pw) ? m_wd : 128'h0);
    chk("rd_fin", 128'(DDR2cache_rd_fin), 128'(m_rd_fin));
    chk("wr_fin", 128'(DDR2cache_wr_fin), 128'(m_wr_fin));
    chk("rd_data", DDR2cache_rd_data, m_rd_data);
    chk("arb_err", 128'(arb_err), 128'(m_err));
    if (rstn) begin
      rclr = m_busy && m_acc && !m_is_wr && ddr_rd_valid;
      wclr = m_busy && m_acc && m_is_wr && ddr_wr_done;
      if (ddr_rd_valid && !rclr) m_err = 1;
      if (ddr_wr_done && !wclr) m_err = 1;
      m_rd_fin = rclr;
      m_wr_fin = wclr;
      if (rclr) m_rd_data = ddr_rd_data;
      if (ev && ddr_cmd_ready) acc_count++;
      if (m_busy) begin
        if (!m_acc) m_acc = ddr_cmd_ready;
        else if (rclr || wclr) m_busy = 0;
      end else if (m_rp || m_wp) begin
        if (m_rp && m_wp && m_ra[26:4] != m_wa[26:4]) m_last_wr = pw;
        m_busy = 1; m_is_wr = pw; m_acc = ddr_cmd_ready;
      end
      if (cache2DDR_rd_en) begin
        if (m_rp && !rclr) m_err = 1;
        else begin m_rp = 1; m_ra = cache2DDR_rd_addr; end
      end else if (rclr) m_rp = 0;
      if (cache2DDR_wr_en) begin
        if (m_wp && !wclr) m_err = 1;
        else begin m_wp = 1; m_wa = cache2DDR_wr_addr; m_wd = cache2DDR_wr_data; end
      end else if (wclr) m_wp = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  // Called in a cycle where a command is presented with ddr_cmd_ready=1: accept, then answer it.
  task automatic complete_cur();
    tick();
    if (m_is_wr) ddr_wr_done = 1'b1;
    else begin
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = {$urandom, $urandom, $urandom, $urandom};
    end
    tick();
    ddr_wr_done  = 1'b0;
    ddr_rd_valid = 1'b0;
  endtask

  initial begin
    int a0;
    model_reset();
    rstn = 1'b0;
    cache2DDR_rd_addr = '0; cache2DDR_rd_en = 0;
    cache2DDR_wr_addr = '0; cache2DDR_wr_data = '0; cache2DDR_wr_en = 0;
    ddr_cmd_ready = 0; ddr_rd_valid = 0; ddr_rd_data = '0; ddr_wr_done = 0;
    tick(3);
    rstn = 1'b1;
    tick(2);

    // 1: single fill
    cache2DDR_rd_en = 1; cache2DDR_rd_addr = 27'h0000040; ddr_cmd_ready = 1;
    tick();
    cache2DDR_rd_en = 0;
    @(negedge clk);
    chk("t1_valid", 128'(ddr_cmd_valid), 128'h1);
    chk("t1_cmd_wr", 128'(ddr_cmd_wr), 128'h0);
    chk("t1_addr", 128'(ddr_cmd_addr), 128'h40);
    tick();
    tick(2);
    ddr_rd_valid = 1; ddr_rd_data = 128'hA5;
    tick();
    ddr_rd_valid = 0; ddr_rd_data = '0;
    @(negedge clk);
    chk("t1_rd_fin", 128'(DDR2cache_rd_fin), 128'h1);
    chk("t1_rd_data", DDR2cache_rd_data, 128'hA5);
    tick();
    @(negedge clk);
    chk("t1_fin_pulse", 128'(DDR2cache_rd_fin), 128'h0);
    tick();

    // 2: same-line hazard, write-back first
    cache2DDR_wr_en = 1; cache2DDR_wr_addr = 27'h0000044; cache2DDR_wr_data = 128'h9999;
    cache2DDR_rd_en = 1; cache2DDR_rd_addr = 27'h0000048;
    tick();
    cache2DDR_wr_en = 0; cache2DDR_rd_en = 0;
    @(negedge clk);
    chk("t2_first_wr", 128'(ddr_cmd_wr), 128'h1);
    chk("t2_wr_addr", 128'(ddr_cmd_addr), 128'h40);
    chk("t2_wr_data", ddr_wr_data, 128'h9999);
    complete_cur();
    @(negedge clk);
    chk("t2_wr_fin", 128'(DDR2cache_wr_fin), 128'h1);
    chk("t2_then_rd_valid", 128'(ddr_cmd_valid), 128'h1);
    chk("t2_then_rd", 128'(ddr_cmd_wr), 128'h0);
    complete_cur();
    tick(2);

    // 3: no hazard, both pending
    cache2DDR_rd_en = 1; cache2DDR_rd_addr = 27'h0000100;
    cache2DDR_wr_en = 1; cache2DDR_wr_addr = 27'h0000200; cache2DDR_wr_data = 128'h1234;
    tick();
    cache2DDR_wr_en = 0; cache2DDR_rd_en = 0;
    @(negedge clk);
    chk("t3_rd_first", 128'(ddr_cmd_wr), 128'h0);
    chk("t3_rd_addr", 128'(ddr_cmd_addr), 128'h100);
    complete_cur();
    @(negedge clk);
    chk("t3_wr_addr", 128'(ddr_cmd_addr), 128'h200);
    complete_cur();
    tick(2);
    cache2DDR_rd_en = 1; cache2DDR_rd_addr = 27'h0000300;
    cache2DDR_wr_en = 1; cache2DDR_wr_addr = 27'h0000400; cache2DDR_wr_data = 128'h5678;
    tick();
    cache2DDR_wr_en = 0; cache2DDR_rd_en = 0;
    @(negedge clk);
`ifdef ARB_RR_EN
    chk("t3_pair2_grant", 128'(ddr_cmd_wr), 128'h1);
`else
    chk("t3_pair2_grant", 128'(ddr_cmd_wr), 128'h0);
`endif
    complete_cur();
    complete_cur();
    tick(2);

    // 4: backpressure on a write
    ddr_cmd_ready = 0;
    cache2DDR_wr_en = 1; cache2DDR_wr_addr = 27'h1234567; cache2DDR_wr_data = 128'hCAFE;
    tick();
    cache2DDR_wr_en = 0;
    a0 = acc_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 128'(ddr_cmd_valid), 128'h1);
      chk("t4_hold_addr", 128'(ddr_cmd_addr), 128'h1234560);
      chk("t4_hold_data", ddr_wr_data, 128'hCAFE);
      tick();
    end
    ddr_cmd_ready = 1;
    complete_cur();
    chk("t4_one_accept", 128'(acc_count - a0), 128'h1);
    tick(2);

    // 5: overflow, then stray write-done after a clean reset
    ddr_cmd_ready = 0;
    cache2DDR_rd_en = 1; cache2DDR_rd_addr = 27'h0000500;
    tick();
    cache2DDR_rd_addr = 27'h0000600;
    tick();
    cache2DDR_rd_en = 0;
    @(negedge clk);
    chk("t5_ovf_err", 128'(arb_err), 128'h1);
    chk("t5_addr_kept", 128'(ddr_cmd_addr), 128'h500);
    ddr_cmd_ready = 1;
    complete_cur();
    tick(2);
    do_reset();
    tick(2);
    ddr_wr_done = 1;
    tick();
    ddr_wr_done = 0;
    @(negedge clk);
    chk("t5_stray_err", 128'(arb_err), 128'h1);
    chk("t5_no_fin", 128'(DDR2cache_wr_fin), 128'h0);
    chk("t5_no_cmd", 128'(ddr_cmd_valid), 128'h0);
    tick();
    do_reset();

    // 6: reset while waiting for read data
    cache2DDR_rd_en = 1; cache2DDR_rd_addr = 27'h0000700;
    tick();
    cache2DDR_rd_en = 0;
    tick();
    rstn = 0;
    @(negedge clk);
    chk("t6_rst_valid", 128'(ddr_cmd_valid), 128'h0);
    chk("t6_rst_err", 128'(arb_err), 128'h0);
    tick();
    rstn = 1;
    tick();
    ddr_rd_valid = 1; ddr_rd_data = 128'hBEEF;
    tick();
    ddr_rd_valid = 0;
    @(negedge clk);
    chk("t6_late_err", 128'(arb_err), 128'h1);
    chk("t6_no_fin", 128'(DDR2cache_rd_fin), 128'h0);
    chk("t6_no_cmd", 128'(ddr_cmd_valid), 128'h0);
    tick();
    do_reset();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rstn = (c % 500 == 499) ? 1'b0 : 1'b1;
      cache2DDR_rd_en = ($urandom % 4 == 0) && (!m_rp || ($urandom % 25 == 0));
      cache2DDR_rd_addr = ($urandom % 8 == 0) ? 27'($urandom) : 27'($urandom_range(0, 63));
      cache2DDR_wr_en = ($urandom % 4 == 0) && (!m_wp || ($urandom % 25 == 0));
      cache2DDR_wr_addr = ($urandom % 8 == 0) ? 27'($urandom) : 27'($urandom_range(0, 63));
      cache2DDR_wr_data = {$urandom, $urandom, $urandom, $urandom};
      ddr_cmd_ready = ($urandom % 3) != 0;
      ddr_rd_data = {$urandom, $urandom, $urandom, $urandom};
      ddr_rd_valid = 0;
      ddr_wr_done = 0;
      if (m_busy && m_acc && ($urandom % 3 == 0)) begin
        if (m_is_wr) ddr_wr_done = 1;
        else ddr_rd_valid = 1;
      end else if ($urandom % 250 == 0) begin
        if ($urandom % 2 == 0) ddr_rd_valid = 1;
        else ddr_wr_done = 1;
      end
      tick();
    end
    rstn = 1; cache2DDR_rd_en = 0; cache2DDR_wr_en = 0; ddr_rd_valid = 0; ddr_wr_done = 0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
